buffer_wr_arbiter: RTL and testbench



---
 rtl/buffer_pkg.sv | 17 +
 rtl/rr_priority_enc.sv | 23 ++
 rtl/buffer_wr_arbiter.sv | 97 +++++++++
 tb/tb_buffer_wr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared definitions for the FIFO buffer and its write-side arbiter.
package buffer_pkg;

   localparam int unsigned BIT_WIDTH = 16;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Never returns less than 1 so that derived vector widths stay legal.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_priority_enc.sv
// Round-robin priority encoder: first set request at or after rr_ptr_i, wrapping.
module rr_priority_enc #(
   parameter int unsigned n_req = 4,
   parameter int unsigned id_w  = 2
) (
   input  logic [n_req-1:0] req_i,
   input  logic [id_w-1:0]  rr_ptr_i,
   output logic             found_o,
   output logic [id_w-1:0]  index_o
);

   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      for (int unsigned k = 0; k < n_req; k++) begin
         if (!found_o && req_i[(32'(rr_ptr_i) + k) % n_req]) begin
            found_o = 1'b1;
            index_o = id_w'((32'(rr_ptr_i) + k) % n_req);
         end
      end
   end

endmodule

// File: rtl/buffer_wr_arbiter.sv
// Round-robin burst arbiter sharing the buffer write port among n_req producers.
module buffer_wr_arbiter
   import buffer_pkg::*;
#(
   parameter  int unsigned n_req     = 4,
   parameter  int unsigned bit_width = BIT_WIDTH,
   parameter  int unsigned burst_len = 4,
   localparam int unsigned id_w      = clog2(n_req)
) (
   input  logic                       clk_w,
   input  logic                       rst,
   input  logic [n_req-1:0]           req,
   input  logic [n_req*bit_width-1:0] data_in,
   input  logic                       full,
   output logic [n_req-1:0]           ack,
   output logic                       load,
   output logic [bit_width-1:0]       data_out,
   output logic [id_w-1:0]            grant_id,
   output logic                       busy
);

   localparam int unsigned cnt_w = clog2(burst_len);

   logic [0:0]       state_q, state_d;
   logic [id_w-1:0]  rr_ptr_q, rr_ptr_d;
   logic [id_w-1:0]  owner_q, owner_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;

   logic             found;
   logic [id_w-1:0]  pick;
   logic [n_req-1:0] owner_oh;
   logic             own_req;
   logic             xfer;
   logic [bit_width-1:0] sel_word;

   rr_priority_enc #(
      .n_req (n_req),
      .id_w  (id_w)
   ) u_enc (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (found),
      .index_o  (pick)
   );

   assign owner_oh = n_req'(1) << owner_q;
   assign own_req  = |(req & owner_oh);
   // rst gating keeps the buffer from loading in a cycle that is being reset
   assign xfer     = (state_q == ST_GRANT) && own_req && !full && !rst;

   always_comb begin
      sel_word = '0;
      for (int unsigned i = 0; i < n_req; i++) begin
         if (owner_q == id_w'(i)) sel_word = data_in[i*bit_width +: bit_width];
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      if (state_q == ST_IDLE) begin
         if (found) begin
            owner_d = pick;
            cnt_d   = '0;
            state_d = ST_GRANT;
         end
      end else if (!own_req || (xfer && cnt_q == cnt_w'(burst_len - 1))) begin
         rr_ptr_d = (owner_q == id_w'(n_req - 1)) ? '0 : owner_q + 1'b1;
         state_d  = ST_IDLE;
      end else if (xfer) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_w) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
      end
   end

   assign load     = xfer;
   assign ack      = xfer ? owner_oh : '0;
   assign data_out = xfer ? sel_word : '0;
   assign grant_id = owner_q;
   assign busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// Randomized and directed checks of buffer_wr_arbiter against a transaction-level model.
module tb_buffer_wr_arbiter;

   localparam int N = 4;
   localparam int W = 16;
   localparam int B = 4;

   logic           clk_w = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data_in;
   logic           full;
   logic [N-1:0]   ack;
   logic           load;
   logic [W-1:0]   data_out;
   logic [1:0]     grant_id;
   logic           busy;

   logic [W-1:0]   words [N];

   // model of arbitration: who holds the port, words moved, next search start
   bit m_busy;
   int m_owner, m_cnt, m_ptr;

   int n_vec = 0;
   int n_err = 0;
   bit auto_prod = 1'b0;
   bit prev_busy = 1'b0;
   int grants[$];
   logic [W-1:0] loads_q[$];

   buffer_wr_arbiter #(
      .n_req     (N),
      .bit_width (W),
      .burst_len (B)
   ) dut (
      .clk_w    (clk_w),
      .rst      (rst),
      .req      (req),
      .data_in  (data_in),
      .full     (full),
      .ack      (ack),
      .load     (load),
      .data_out (data_out),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk_w = ~clk_w;

   always_comb begin
      for (int i = 0; i < N; i++) data_in[i*W +: W] = words[i];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic release_grant();
      m_ptr  = (m_owner + 1) % N;
      m_busy = 1'b0;
   endtask

   // One clock cycle: compare outputs, take the edge, advance the model.
   task automatic tick();
      bit           x;
      int           own;
      logic [N-1:0] one;
      one = 1;
      #1;
      x   = !rst && m_busy && req[m_owner] && !full;
      own = m_owner;
      chk("load", load, x);
      chk("ack", ack, x ? (one << m_owner) : '0);
      chk("data_out", data_out, x ? words[m_owner] : '0);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_owner);
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = busy;
      if (load) loads_q.push_back(data_out);
      @(posedge clk_w);
      if (rst) begin
         m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (req[j]) begin
               m_owner = j; m_cnt = 0; m_busy = 1'b1;
               break;
            end
         end
      end else if (!req[m_owner]) begin
         release_grant();
      end else if (!full) begin
         if (m_cnt == B - 1) release_grant();
         else m_cnt++;
      end
      if (auto_prod && x) words[own] = words[own] + 1'b1;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '1; full = 1'b0;
      for (int i = 0; i < N; i++) words[i] = W'(16'h11 * (i + 1));
      m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      @(posedge clk_w); #1;

      // reset held with all requesting
      tick();
      #1;
      chk("rst_load", load, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", data_out, 0);
      rst = 1'b0;
      tick();
      chk("rst_first_grant", grant_id, 0);
      chk("rst_first_busy", busy, 1);

      // single requester, two full bursts
      do_reset();
      req = 4'b0100; words[2] = 16'h00A0; auto_prod = 1'b1;
      loads_q.delete();
      repeat (10) tick();
      auto_prod = 1'b0;
      chk("single_nloads", loads_q.size(), 8);
      for (int i = 0; i < 8 && i < loads_q.size(); i++)
         chk("single_word", loads_q[i], 16'h00A0 + i);

      // round robin among 0,1,3
      do_reset();
      req = 4'b1011;
      grants.delete();
      repeat (30) tick();
      chk("rr_count", grants.size() >= 6, 1);
      begin
         int exp_order[6] = '{0, 1, 3, 0, 1, 3};
         for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("rr_order", grants[i], exp_order[i]);
      end

      // full stall mid-burst on owner 1
      do_reset();
      req = 4'b0010;
      repeat (3) tick();
      full = 1'b1;
      repeat (3) begin
         #1;
         chk("stall_load", load, 0);
         chk("stall_ack", ack, 0);
         chk("stall_busy", busy, 1);
         chk("stall_gid", grant_id, 1);
         tick();
      end
      full = 1'b0;
      #1;
      chk("resume_load", load, 1);
      repeat (2) tick();
      req = 4'b0110;
      tick();
      #1;
      chk("stall_next_gid", grant_id, 2);

      // owner 3 drops after one word
      do_reset();
      req = 4'b1000;
      repeat (2) tick();
      req = 4'b0001;
      #1;
      chk("drop_load", load, 0);
      repeat (2) tick();
      chk("drop_next_gid", grant_id, 0);
      chk("drop_next_busy", busy, 1);

      // reset in the middle of owner 2's burst
      do_reset();
      req = 4'b0100;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("midrst_load", load, 0);
      tick();
      chk("midrst_busy", busy, 0);
      rst = 1'b0; req = 4'b0101;
      tick();
      chk("midrst_gid", grant_id, 0);
      chk("midrst_regrant", busy, 1);

      // random traffic
      repeat (3000) begin
         rst  = ($urandom_range(0, 63) == 0);
         req  = N'($urandom);
         full = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < N; i++) words[i] = W'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
